modexp_stream_ctrl: RTL and testbench
=====================================

# modexp_stream_ctrl

Synthesizable host-side sequencer that drives one ModExp core end to end, parametrised in operand width and bus word width. It runs the Montgomery precomputation (R via rtMod mode 0, T via rtMod mode 1, n' via modInv), streams operands LSW-first into ModExp, waits for completion and reassembles the result. It caches the precomputation per modulus so that repeated jobs under the same key skip it, and it times out on a hung core.

## Interface
Parameters:
- WIDTH, 4096: operand width in bits; must be a multiple of DW.
- DW, 64: ModExp bus word width (matches `DATA_WIDTH`).
- NW, WIDTH/DW: words per operand (derived).
- COMPLETE_STATE, 9: exp_state encoding for COMPLETE.
- TIMEOUT, 2^24: maximum cycles allowed in any wait state.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- go  in  1  start pulse, sampled only in IDLE
- message / exponent / modulus  in  WIDTH  operands, held stable while busy
- result  out  WIDTH  final ciphertext, valid when done pulses, held until next go
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on success
- timeout  out  1  sticky error flag, cleared by the next accepted go or by reset
- pre_go / pre_mode  out  1/1  rtMod start pulse and mode (0=R, 1=T)
- pre_done / pre_result  in  1/WIDTH  rtMod completion and value
- inv_go  out  1  modInv start pulse
- inv_valid / inv_result  in  1/64  modInv completion and n'
- nprime0  out  64  registered n' presented to ModExp
- startInput / startCompute / getResult  out  1  ModExp control
- m_buf, e_buf, n_buf, r_buf, t_buf  out  DW each  ModExp operand words
- exp_state  in  5  ModExp state
- res_out  in  DW  ModExp result word

## Operation
Reset behaviour:
- All outputs go to 0 and the FSM enters IDLE.
- The cache is invalidated; r_reg, t_reg and nprime0 are cleared.
- Reset mid-job aborts immediately. No done pulse is produced.

States:
- IDLE: on go, latch modulus into n_reg, clear timeout and the word counter, assert busy. If cache_valid and modulus == cached_n, go to SEND_INPUT; otherwise go to CALC_R.
- CALC_R: pulse pre_go with pre_mode=0 for 1 cycle on entry. On pre_done, capture r_reg=pre_result and go to CALC_T.
- CALC_T: pulse pre_go with pre_mode=1 for 1 cycle on entry. On pre_done, capture t_reg and go to CALC_N0.
- CALC_N0: pulse inv_go for 1 cycle on entry. On inv_valid, capture nprime0=inv_result, set cache_valid, set cached_n=n_reg, go to SEND_INPUT.
- SEND_INPUT: startInput=1 for exactly NW cycles. In the k-th cycle (k=0..NW-1), the buses carry word k (bits k*DW+:DW) of m, e, n, r_reg and t_reg. After the last word, go to WAIT_COMPUTE.
- WAIT_COMPUTE: startCompute pulses for 1 cycle on entry; getResult is held at 1. When exp_state==COMPLETE_STATE, reset the counter and go to READ_OUTPUT.
- READ_OUTPUT: in the k-th cycle, result[k*DW+:DW] <= res_out. There is no off-by-one: the first captured word is word 0. After NW cycles, pulse done, drop getResult, go to IDLE.

Timeout:
- A cycle counter resets on each state entry.
- If it reaches TIMEOUT in CALC_R, CALC_T, CALC_N0 or WAIT_COMPUTE, set timeout, invalidate the cache, drop all strobes and go to IDLE. No done pulse.

Boundary rules:
- go while busy is ignored.
- A pre_done or inv_valid arriving in the same cycle as the entry pulse is accepted.
- A spurious pre_done or inv_valid outside its state is ignored.
- Counter width is clog2(NW)+1; the counter never wraps inside a state.

## Timing
- Cache hit: go → first startInput cycle = 1 cycle.
- Total latency on a hit = 1 + NW + 1 + t_core + NW + 1 cycles, where t_core is the number of cycles until exp_state==COMPLETE_STATE.
- Cache miss adds 3 state entries plus rtMod/modInv latency.
- done asserts in the cycle after the last result word is captured; result is stable from that cycle onward.
- busy falls in the same cycle done rises.
- Every strobe (pre_go, inv_go, startCompute, done) is exactly 1 cycle wide.

## Test plan
- Small config (WIDTH=256, DW=64) with behavioural rtMod, modInv and ModExp. Run m=8, e=13, n=77 → done after the expected cycle count, result=50, timeout=0.
- Same modulus rerun with m=3, e=5 → CALC states skipped (pre_go and inv_go never pulse), startInput rises 1 cycle after go, result=243 mod 77=12.
- Stream check: in SEND_INPUT, scoreboard m_buf/n_buf word k against operand bits k*64+:64 for k=0..3 with startInput=1. Inject res_out=0x11..,0x22..,0x33..,0x44.. → result words land in order 0..3.
- Hang: ModExp model never reaches COMPLETE with TIMEOUT=1000 → timeout=1 after 1000 cycles in WAIT_COMPUTE, busy=0, no done. The next go with the same modulus re-runs CALC_R.
- Reset mid-READ_OUTPUT (word 2) → all outputs 0 the next cycle. A following go always re-runs the precomputation.
- go asserted during SEND_INPUT and WAIT_COMPUTE → ignored; only one done per accepted go.

Source files
------------

// File: rtl/modexp_stream_ctrl.sv
// Host-side sequencer for one ModExp core: Montgomery precompute cached per modulus,
// LSW-first operand streaming, result reassembly and a hung-core timeout.
module modexp_stream_ctrl #(
  parameter int WIDTH          = 4096,
  parameter int DW             = 64,
  parameter int NW             = WIDTH / DW,
  parameter int COMPLETE_STATE = 9,
  parameter int TIMEOUT        = 1 << 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             pre_go,
  output logic             pre_mode,
  input  logic             pre_done,
  input  logic [WIDTH-1:0] pre_result,
  output logic             inv_go,
  input  logic             inv_valid,
  input  logic [63:0]      inv_result,
  output logic [63:0]      nprime0,
  output logic             startInput,
  output logic             startCompute,
  output logic             getResult,
  output logic [DW-1:0]    m_buf,
  output logic [DW-1:0]    e_buf,
  output logic [DW-1:0]    n_buf,
  output logic [DW-1:0]    r_buf,
  output logic [DW-1:0]    t_buf,
  input  logic [4:0]       exp_state,
  input  logic [DW-1:0]    res_out
);

  localparam int CW = $clog2(NW) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);
  localparam logic [TW-1:0] TLIMIT    = TW'(TIMEOUT - 1);
  localparam logic [4:0]    COMPLETE  = 5'(COMPLETE_STATE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CALC_R  = 3'd1;
  localparam logic [2:0] S_CALC_T  = 3'd2;
  localparam logic [2:0] S_CALC_N0 = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_READ    = 3'd6;

  logic [2:0]       state;
  logic [CW-1:0]    wcnt;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] t_reg;
  logic [WIDTH-1:0] cached_n;
  logic             cache_valid;
  logic [OW-1:0]    woff;

  assign woff       = OW'(wcnt) * OW'(DW);
  assign busy       = (state != S_IDLE);
  assign startInput = (state == S_SEND);

  always_comb begin
    m_buf = '0;
    e_buf = '0;
    n_buf = '0;
    r_buf = '0;
    t_buf = '0;
    if (state == S_SEND) begin
      m_buf = message[woff +: DW];
      e_buf = exponent[woff +: DW];
      n_buf = n_reg[woff +: DW];
      r_buf = r_reg[woff +: DW];
      t_buf = t_reg[woff +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      tcnt         <= '0;
      n_reg        <= '0;
      r_reg        <= '0;
      t_reg        <= '0;
      cached_n     <= '0;
      cache_valid  <= 1'b0;
      nprime0      <= '0;
      result       <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      pre_go       <= 1'b0;
      pre_mode     <= 1'b0;
      inv_go       <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
    end else begin
      // Strobes default low so each one is a single-cycle pulse on state entry.
      pre_go       <= 1'b0;
      inv_go       <= 1'b0;
      startCompute <= 1'b0;
      done         <= 1'b0;
      tcnt         <= tcnt + TW'(1);
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (go) begin
            n_reg   <= modulus;
            timeout <= 1'b0;
            wcnt    <= '0;
            if (cache_valid && (modulus == cached_n)) begin
              state <= S_SEND;
            end else begin
              state    <= S_CALC_R;
              pre_go   <= 1'b1;
              pre_mode <= 1'b0;
            end
          end
        end
        S_CALC_R, S_CALC_T, S_CALC_N0, S_WAIT: begin
          if ((state == S_CALC_R) && pre_done) begin
            r_reg    <= pre_result;
            state    <= S_CALC_T;
            pre_go   <= 1'b1;
            pre_mode <= 1'b1;
            tcnt     <= '0;
          end else if ((state == S_CALC_T) && pre_done) begin
            t_reg  <= pre_result;
            state  <= S_CALC_N0;
            inv_go <= 1'b1;
            tcnt   <= '0;
          end else if ((state == S_CALC_N0) && inv_valid) begin
            nprime0     <= inv_result;
            cache_valid <= 1'b1;
            cached_n    <= n_reg;
            state       <= S_SEND;
            wcnt        <= '0;
            tcnt        <= '0;
          end else if ((state == S_WAIT) && (exp_state == COMPLETE)) begin
            wcnt  <= '0;
            state <= S_READ;
            tcnt  <= '0;
          end else if (tcnt == TLIMIT) begin
            // Hung core: the partially built precompute can no longer be trusted.
            timeout     <= 1'b1;
            cache_valid <= 1'b0;
            getResult   <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_SEND: begin
          if (wcnt == LAST_WORD) begin
            wcnt         <= '0;
            state        <= S_WAIT;
            startCompute <= 1'b1;
            getResult    <= 1'b1;
            tcnt         <= '0;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_READ: begin
          result[woff +: DW] <= res_out;
          if (wcnt == LAST_WORD) begin
            done      <= 1'b1;
            getResult <= 1'b0;
            state     <= S_IDLE;
            tcnt      <= '0;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_stream_ctrl.sv
// Scoreboard bench for modexp_stream_ctrl with behavioural rtMod, modInv and ModExp cores.
module tb_modexp_stream_ctrl;
  localparam int WIDTH = 256;
  localparam int DW    = 64;
  localparam int NW    = WIDTH / DW;
  localparam int CS    = 9;
  localparam int TMO   = 1000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic [WIDTH-1:0] message = '0, exponent = '0, modulus = '0;
  logic [WIDTH-1:0] result, pre_result;
  logic             busy, done, timeout, pre_go, pre_mode, pre_done, inv_go, inv_valid;
  logic [63:0]      inv_result, nprime0;
  logic             start_input, start_compute, get_result;
  logic [DW-1:0]    m_buf, e_buf, n_buf, r_buf, t_buf, res_out;
  logic [4:0]       exp_state;
  logic             outs_or;

  modexp_stream_ctrl #(
    .WIDTH(WIDTH), .DW(DW), .COMPLETE_STATE(CS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .message(message), .exponent(exponent), .modulus(modulus),
    .result(result), .busy(busy), .done(done), .timeout(timeout),
    .pre_go(pre_go), .pre_mode(pre_mode), .pre_done(pre_done), .pre_result(pre_result),
    .inv_go(inv_go), .inv_valid(inv_valid), .inv_result(inv_result), .nprime0(nprime0),
    .startInput(start_input), .startCompute(start_compute), .getResult(get_result),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .exp_state(exp_state), .res_out(res_out)
  );

  always #5 clk = ~clk;

  assign outs_or = |{result, busy, done, timeout, pre_go, pre_mode, inv_go, nprime0,
                     start_input, start_compute, get_result, m_buf, e_buf, n_buf, r_buf, t_buf};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- arithmetic reference ----------------
  function automatic logic [WIDTH-1:0] mod_pow(input logic [WIDTH-1:0] b, e, n);
    logic [2*WIDTH-1:0] acc, base, nn;
    nn   = {{WIDTH{1'b0}}, n};
    acc  = 1;
    acc  = acc % nn;
    base = {{WIDTH{1'b0}}, b} % nn;
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) acc = (acc * base) % nn;
      base = (base * base) % nn;
    end
    return acc[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] calc_r(input logic [WIDTH-1:0] n);
    logic [2*WIDTH-1:0] x;
    x = 1;
    x = (x << WIDTH) % {{WIDTH{1'b0}}, n};
    return x[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] calc_t(input logic [WIDTH-1:0] n);
    logic [2*WIDTH-1:0] r;
    r = {{WIDTH{1'b0}}, calc_r(n)};
    r = (r * r) % {{WIDTH{1'b0}}, n};
    return r[WIDTH-1:0];
  endfunction

  // -n^-1 mod 2^64 by Newton iteration (n odd)
  function automatic logic [63:0] calc_np(input logic [WIDTH-1:0] n);
    logic [63:0] x, a;
    a = n[63:0];
    x = 64'd1;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - a * x);
    return -x;
  endfunction

  function automatic logic [WIDTH-1:0] rand_w();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- behavioural cores ----------------
  int               pre_lat = 1, core_lat = 2;
  bit               hang = 1'b0, inject = 1'b0, spur_en = 1'b0;
  logic [WIDTH-1:0] mdl_r = '0, mdl_t = '0;
  logic [63:0]      mdl_np = '0;
  int               pcnt, icnt, ccnt, sk, rk;
  logic             pmode_q, rd;
  logic [WIDTH-1:0] cm, ce, cn, cres;
  logic [3:0]       inj_nib;

  always @(posedge clk) begin
    if (reset) begin
      pcnt <= 0; icnt <= 0; pmode_q <= 1'b0;
    end else begin
      if (pre_go) begin pcnt <= pre_lat; pmode_q <= pre_mode; end
      else if (pcnt > 0) pcnt <= pcnt - 1;
      if (inv_go) icnt <= pre_lat;
      else if (icnt > 0) icnt <= icnt - 1;
    end
  end

  always_comb begin
    pre_done   = (pre_lat == 0) ? pre_go : (pcnt == 1);
    pre_result = ((pre_lat == 0) ? pre_mode : pmode_q) ? mdl_t : mdl_r;
    inv_valid  = (pre_lat == 0) ? inv_go : (icnt == 1);
    inv_result = mdl_np;
    if (spur_en && start_input) begin
      pre_done   = 1'b1;
      pre_result = {8{32'hdeadbeef}};
      inv_valid  = 1'b1;
      inv_result = 64'hbadbadbadbadbad0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      exp_state <= 5'd0; ccnt <= 0; sk <= 0; rk <= 0; rd <= 1'b0;
    end else begin
      if (start_input) begin
        cm[sk*DW +: DW] <= m_buf;
        ce[sk*DW +: DW] <= e_buf;
        cn[sk*DW +: DW] <= n_buf;
        sk <= sk + 1;
        exp_state <= 5'd0;
      end else begin
        sk <= 0;
      end
      if (start_compute) begin
        exp_state <= 5'd3;
        ccnt <= core_lat - 1;
        cres <= mod_pow(cm, ce, cn);
      end else if (!hang && ccnt > 0) begin
        if (ccnt == 1) exp_state <= 5'(CS);
        ccnt <= ccnt - 1;
      end
      if (exp_state == 5'(CS) && get_result) begin
        if (rd) rk <= rk + 1;
        rd <= 1'b1;
      end else begin
        rd <= 1'b0; rk <= 0;
      end
    end
  end

  always_comb begin
    inj_nib = 4'(rk + 1);
    if (rk >= NW)    res_out = '0;
    else if (inject) res_out = {16{inj_nib}};
    else             res_out = cres[rk*DW +: DW];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [WIDTH-1:0] res;
    int               dc;
  } exp_t;
  exp_t        res_q[$];
  logic [383:0] str_q[$];
  int npre = 0, ninv = 0, last_sc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pre_go) npre++;
        if (inv_go) ninv++;
        if (start_compute) last_sc = cyc;
        if (start_input) begin
          if (str_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stream_extra: got startInput=1 expected no stream word");
          end else begin
            chk("stream_word", 512'({m_buf, e_buf, n_buf, r_buf, t_buf, nprime0}),
                512'(str_q.pop_front()));
          end
        end
        if (done) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done: got done=1 expected 0");
          end else begin
            exp_t x;
            x = res_q.pop_front();
            chk("result", 512'({result, timeout}), 512'({x.res, 1'b0}));
            if (x.dc >= 0) chk("done_cycle", 512'(cyc), 512'(x.dc));
          end
        end
      end
    end
  end

  // Cache model: which modulus has valid precompute, per the operating rules.
  bit               ref_valid = 1'b0;
  logic [WIDTH-1:0] ref_n = '0;
  logic [63:0]      ref_np = '0;

  // mode: 0 normal, 1 go pokes while busy, 2 reset at read word 2, 3 hung core
  task automatic run_job(input logic [WIDTH-1:0] m, e, n, expres, input int mode,
                         input int plat, input int clat, input bit spur);
    bit          hit;
    int          g, p0, i0, nw;
    logic [63:0] np_exp;
    exp_t        x;
    hit = ref_valid && (ref_n == n);
    @(negedge clk);
    pre_lat = plat; core_lat = clat; spur_en = spur; hang = (mode == 3);
    message = m; exponent = e; modulus = n;
    mdl_r = calc_r(n); mdl_t = calc_t(n); mdl_np = calc_np(n);
    np_exp = hit ? ref_np : calc_np(n);
    for (int k = 0; k < NW; k++)
      str_q.push_back({m[k*DW +: DW], e[k*DW +: DW], n[k*DW +: DW],
                       mdl_r[k*DW +: DW], mdl_t[k*DW +: DW], np_exp});
    g = cyc;
    if (mode == 0 || mode == 1) begin
      x.res = expres;
      x.dc  = hit ? g + 2 * NW + 2 + clat : -1;
      res_q.push_back(x);
    end
    p0 = npre; i0 = ninv;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    if (hit) chk("hit_start_input", 512'(start_input), 512'(1));
    nw = 0;
    while (busy && nw < 3000) begin
      if (mode == 1) go = start_input || start_compute;
      if (mode == 2 && rd && rk == 2) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", 512'(outs_or), 512'(0));
        break;
      end
      @(negedge clk);
      nw++;
    end
    go = 1'b0;
    chk("idle_after_job", 512'(busy), 512'(0));
    chk("pre_go_count", 512'(npre - p0), 512'(hit ? 0 : 2));
    chk("inv_go_count", 512'(ninv - i0), 512'(hit ? 0 : 1));
    if (mode == 3) begin
      chk("timeout_flag", 512'({busy, timeout}), 512'(2'b01));
      chk("timeout_cycle", 512'(cyc), 512'(last_sc + TMO));
    end
    if (mode == 0 || mode == 1) begin
      ref_valid = 1'b1; ref_n = n; ref_np = np_exp;
    end else begin
      ref_valid = 1'b0;
    end
    hang = 1'b0; spur_en = 1'b0;
  endtask

  logic [WIDTH-1:0] pool[3];
  logic [WIDTH-1:0] inj_res, rm, re, rn;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", 512'(outs_or), 512'(0));
    reset = 1'b0;

    run_job(256'd8, 256'd13, 256'd77, 256'd50, 0, 2, 5, 1'b0);
    run_job(256'd3, 256'd5, 256'd77, 256'd12, 0, 1, 3, 1'b0);

    inject = 1'b1;
    inj_res = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_job(256'd9, 256'd7, 256'd77, inj_res, 0, 1, 2, 1'b0);
    inject = 1'b0;

    run_job(256'd9, 256'd7, 256'd77, '0, 3, 1, 2, 1'b0);
    run_job(256'd10, 256'd3, 256'd77, 256'd76, 1, 0, 4, 1'b0);
    run_job(256'd2, 256'd10, 256'd77, '0, 2, 1, 2, 1'b0);
    run_job(256'd2, 256'd10, 256'd77, 256'd23, 0, 0, 2, 1'b1);

    pool[0] = 256'd77;
    for (int i = 1; i < 3; i++) pool[i] = rand_w() | 256'd1 | (256'd1 << (WIDTH - 1));
    for (int j = 0; j < 8; j++) begin
      rn = pool[$urandom_range(0, 2)];
      rm = rand_w();
      re = rand_w();
      run_job(rm, re, rn, mod_pow(rm, re, rn), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), int'($urandom_range(2, 12)),
              1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queues_drained", 512'(res_q.size() + str_q.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
